// File: rtl/map_pkg.sv
// Shared types and constants for the map ROM port arbiter.
package map_pkg;

    localparam int ADDR_W = 5;
    localparam int ROW_W  = 1 << ADDR_W;

    typedef enum logic [1:0] {
        IDLE,
        VID_RD,
        Q_RD
    } state_e;

    // Column 0 is the MSB of a row. Because ROW_W == 2^ADDR_W, the bit
    // index ROW_W-1-x is simply the bitwise complement of x.
    function automatic logic cell_bit(input logic [ROW_W-1:0] row,
                                      input logic [ADDR_W-1:0] x);
        return row[~x];
    endfunction

endpackage

// File: rtl/map_port_arbiter_if.sv
// Requester-side bundle: video line fetch and game-logic cell query.
interface map_port_arbiter_if;
    import map_pkg::*;

    logic              video_row_req;
    logic [ADDR_W-1:0] video_row;
    logic [ADDR_W-1:0] video_col;
    logic              video_pixel;
    logic              line_ready;
    logic              vid_overrun;

    logic              query_valid;
    logic              query_ready;
    logic [ADDR_W-1:0] query_x;
    logic [ADDR_W-1:0] query_y;
    logic              resp_valid;
    logic              resp_hit;

    // Arbiter side.
    modport slave (
        input  video_row_req, video_row, video_col,
        input  query_valid, query_x, query_y,
        output video_pixel, line_ready, vid_overrun,
        output query_ready, resp_valid, resp_hit
    );

    // Requester side (video fetcher and game logic).
    modport master (
        output video_row_req, video_row, video_col,
        output query_valid, query_x, query_y,
        input  video_pixel, line_ready, vid_overrun,
        input  query_ready, resp_valid, resp_hit
    );

endinterface

// File: rtl/map_line_buffer.sv
// One map row held for the current scanline, with a column read mux.
module map_line_buffer
    import map_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [ROW_W-1:0]  row_in,
    input  logic [ADDR_W-1:0] col,
    output logic              pixel
);

    logic [ROW_W-1:0] line_buf_q;
    logic [ROW_W-1:0] line_buf_d;

    // Next line contents: replaced only on the capture cycle of a video read.
    always_comb begin
        line_buf_d = line_buf_q;
        if (load) begin
            line_buf_d = row_in;
        end
    end

    // Line register.
    // NOTE: this is a single register rather than a memory array, so it is
    // cleared on reset and video_pixel is defined from the first cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            line_buf_q <= '0;
        end else begin
            line_buf_q <= line_buf_d;
        end
    end

    assign pixel = cell_bit(line_buf_q, col);

endmodule

// File: rtl/map_port_arbiter.sv
// Shares the map ROM row port between the video line fetcher (priority)
// and the collision query port; a wait counter bounds query starvation.
module map_port_arbiter
    import map_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic [ADDR_W-1:0]        map_addr,
    input  logic [ROW_W-1:0]         map_bits,
    map_port_arbiter_if.slave        bus
);

    localparam int                WAIT_W   = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_SAT = WAIT_W'(MAX_WAIT);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] map_addr_q, map_addr_d;
    logic [ADDR_W-1:0] qx_q, qx_d;
    logic              vid_pending_q, vid_pending_d;
    logic [ADDR_W-1:0] pend_row_q, pend_row_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              line_ready_q, line_ready_d;
    logic              resp_valid_q, resp_valid_d;
    logic              resp_hit_q, resp_hit_d;
    logic              vid_overrun_q, vid_overrun_d;

    logic              vid_dem;
    logic [ADDR_W-1:0] vid_row;
    logic              q_win;
    logic              is_idle;
    logic              query_ready;
    logic              vid_granted;
    logic              load_line;

    // Arbitration terms: who would win the port if it were free this cycle.
    always_comb begin
        vid_dem     = bus.video_row_req | vid_pending_q;
        vid_row     = bus.video_row_req ? bus.video_row : pend_row_q;
        q_win       = bus.query_valid & ((wait_cnt_q >= WAIT_SAT) | ~vid_dem);
        is_idle     = (state_q == IDLE);
        query_ready = is_idle & q_win;
        vid_granted = is_idle & ~q_win;
    end

    // Next-state, access sequencing, pending-video and wait-counter updates.
    // NOTE: every _d gets a default before any branch, so no path leaves a
    // signal unassigned and no latch is inferred.
    always_comb begin
        state_d       = state_q;
        map_addr_d    = map_addr_q;
        qx_d          = qx_q;
        vid_pending_d = vid_pending_q;
        pend_row_d    = pend_row_q;
        wait_cnt_d    = wait_cnt_q;
        line_ready_d  = 1'b0;
        resp_valid_d  = 1'b0;
        resp_hit_d    = resp_hit_q;
        vid_overrun_d = vid_overrun_q;
        load_line     = 1'b0;

        case (state_q)
            IDLE: begin
                if (q_win) begin
                    map_addr_d = bus.query_y;
                    qx_d       = bus.query_x;
                    state_d    = Q_RD;
                end else if (vid_dem) begin
                    map_addr_d    = vid_row;
                    vid_pending_d = 1'b0;
                    state_d       = VID_RD;
                end
            end
            VID_RD: begin
                load_line    = 1'b1;
                line_ready_d = 1'b1;
                state_d      = IDLE;
            end
            Q_RD: begin
                resp_hit_d   = cell_bit(map_bits, qx_q);
                resp_valid_d = 1'b1;
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A video request that cannot be granted now is parked; parking over
        // an unserved one loses that row and is flagged.
        if (bus.video_row_req && !vid_granted) begin
            vid_pending_d = 1'b1;
            pend_row_d    = bus.video_row;
            if (vid_pending_q) begin
                vid_overrun_d = 1'b1;
            end
        end

        // Count cycles a valid query is refused, saturating; clear on accept.
        if (query_ready) begin
            wait_cnt_d = '0;
        end else if (bus.query_valid && (wait_cnt_q != WAIT_SAT)) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end
    end

    // State registers with synchronous reset.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            map_addr_q    <= '0;
            qx_q          <= '0;
            vid_pending_q <= 1'b0;
            pend_row_q    <= '0;
            wait_cnt_q    <= '0;
            line_ready_q  <= 1'b0;
            resp_valid_q  <= 1'b0;
            resp_hit_q    <= 1'b0;
            vid_overrun_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            map_addr_q    <= map_addr_d;
            qx_q          <= qx_d;
            vid_pending_q <= vid_pending_d;
            pend_row_q    <= pend_row_d;
            wait_cnt_q    <= wait_cnt_d;
            line_ready_q  <= line_ready_d;
            resp_valid_q  <= resp_valid_d;
            resp_hit_q    <= resp_hit_d;
            vid_overrun_q <= vid_overrun_d;
        end
    end

    map_line_buffer u_line_buffer (
        .clk    (clk),
        .reset  (reset),
        .load   (load_line),
        .row_in (map_bits),
        .col    (bus.video_col),
        .pixel  (bus.video_pixel)
    );

    assign map_addr        = map_addr_q;
    assign bus.query_ready = query_ready;
    assign bus.line_ready  = line_ready_q;
    assign bus.resp_valid  = resp_valid_q;
    assign bus.resp_hit    = resp_hit_q;
    assign bus.vid_overrun = vid_overrun_q;

endmodule

// File: tb/tb_map_port_arbiter.sv
// Self-checking bench for map_port_arbiter with a stub map ROM and
// scoreboard queues for line fetches and query responses.
module tb_map_port_arbiter;
    import map_pkg::*;

    localparam int MAX_WAIT = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [ADDR_W-1:0] map_addr;
    logic [ROW_W-1:0]  map_bits;

    map_port_arbiter_if bus ();

    map_port_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
        .clk      (clk),
        .reset    (reset),
        .map_addr (map_addr),
        .map_bits (map_bits),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int last_line_cyc = 0;
    int last_resp_cyc = 0;
    bit vid_chk_en = 1'b1;

    logic [ADDR_W-1:0] vid_exp[$];
    logic              q_exp[$];

    // Stub ROM: row 3 is the test pattern, other rows are address-derived.
    function automatic logic [31:0] rom_row(input logic [4:0] a);
        if (a == 5'd3) return 32'h8000_0001;
        return {a, ~a, a, ~a, a, ~a, a[4:3]};
    endfunction

    function automatic logic exp_bit(input logic [4:0] row, input logic [4:0] x);
        logic [31:0] r;
        r = rom_row(row);
        return r[5'd31 - x];
    endfunction

    assign map_bits = rom_row(map_addr);

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Scoreboard: push query expectations on accept, pop on each response.
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.line_ready) begin
                last_line_cyc = cyc;
                if (vid_chk_en) begin
                    if (vid_exp.size() == 0) begin
                        check("line_unexpected", 1, 0);
                    end else begin
                        logic [ADDR_W-1:0] r;
                        r = vid_exp.pop_front();
                        check("line_row", map_addr, r);
                        check("line_pixel", bus.video_pixel, exp_bit(r, bus.video_col));
                    end
                end
            end
            if (bus.resp_valid) begin
                last_resp_cyc = cyc;
                if (q_exp.size() == 0) check("resp_unexpected", 1, 0);
                else check("resp_hit", bus.resp_hit, q_exp.pop_front());
            end
            if (bus.query_valid && bus.query_ready) begin
                q_exp.push_back(exp_bit(bus.query_y, bus.query_x));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int blocked;
        int n_acc;
        bit first;
        bit acc;

        bus.video_row_req = 1'b0;
        bus.video_row     = '0;
        bus.video_col     = '0;
        bus.query_valid   = 1'b0;
        bus.query_x       = '0;
        bus.query_y       = '0;
        reset             = 1'b1;
        tick();
        tick();

        // Reset state
        check("rst_map_addr", map_addr, 0);
        check("rst_line_ready", bus.line_ready, 0);
        check("rst_resp_valid", bus.resp_valid, 0);
        check("rst_resp_hit", bus.resp_hit, 0);
        check("rst_overrun", bus.vid_overrun, 0);
        check("rst_pixel", bus.video_pixel, 0);
        reset = 1'b0;

        // Video fetch of row 3, line_ready two cycles after the request
        bus.video_row_req = 1'b1;
        bus.video_row     = 5'd3;
        vid_exp.push_back(5'd3);
        tick();
        bus.video_row_req = 1'b0;
        check("vid_lat_early", bus.line_ready, 0);
        tick();
        check("vid_lat", bus.line_ready, 1);
        tick();
        bus.video_col = 5'd0;  #1 check("pix_col0", bus.video_pixel, 1);
        bus.video_col = 5'd31; #1 check("pix_col31", bus.video_pixel, 1);
        bus.video_col = 5'd5;  #1 check("pix_col5", bus.video_pixel, 0);
        for (int c = 0; c < 32; c++) begin
            bus.video_col = 5'(c);
            #1 check("pix_sweep", bus.video_pixel, exp_bit(5'd3, 5'(c)));
        end
        bus.video_col = '0;
        tick();

        // Query with no video activity: accepted the same cycle
        bus.query_valid = 1'b1;
        bus.query_x     = 5'd31;
        bus.query_y     = 5'd3;
        #1 check("q_ready_idle", bus.query_ready, 1);
        tick();
        bus.query_valid = 1'b0;
        check("q_lat_early", bus.resp_valid, 0);
        tick();
        check("q_lat_valid", bus.resp_valid, 1);
        check("q_hit_x31", bus.resp_hit, 1);
        bus.query_valid = 1'b1;
        bus.query_x     = 5'd1;
        tick();
        bus.query_valid = 1'b0;
        check("q_hit_hold", bus.resp_hit, 1);
        tick();
        check("q_lat_valid2", bus.resp_valid, 1);
        check("q_hit_x1", bus.resp_hit, 0);
        tick();

        // Simultaneous video and query with wait_cnt=0: video first
        bus.video_row_req = 1'b1;
        bus.video_row     = 5'd5;
        bus.query_valid   = 1'b1;
        bus.query_x       = 5'd2;
        bus.query_y       = 5'd10;
        vid_exp.push_back(5'd5);
        #1 check("sim_q_blocked", bus.query_ready, 0);
        tick();
        bus.video_row_req = 1'b0;
        check("sim_vid_addr", map_addr, 5);
        check("sim_busy_ready", bus.query_ready, 0);
        tick();
        check("sim_line_ready", bus.line_ready, 1);
        check("sim_q_accept", bus.query_ready, 1);
        tick();
        bus.query_valid = 1'b0;
        check("sim_q_addr", map_addr, 10);
        tick();
        check("sim_resp_valid", bus.resp_valid, 1);
        @(negedge clk);
        #1 check("sim_order", last_line_cyc < last_resp_cyc, 1);
        tick();

        // Video every 2 cycles with a continuous query: bounded starvation.
        // After the first accept, the query's own Q_RD cycle also counts as
        // a refused cycle, so later gaps may reach MAX_WAIT+1.
        vid_chk_en      = 1'b0;
        bus.query_valid = 1'b1;
        bus.query_x     = 5'd4;
        bus.query_y     = 5'd6;
        blocked = 0;
        n_acc   = 0;
        first   = 1'b1;
        for (int i = 0; i < 40; i++) begin
            bus.video_row_req = (i % 2 == 0);
            bus.video_row     = 5'(i);
            #1;
            acc = bus.query_ready;
            if (acc) begin
                if (first) check("fair_first", blocked, MAX_WAIT);
                else       check("fair_bound", blocked <= MAX_WAIT + 1, 1);
                first   = 1'b0;
                blocked = 0;
                n_acc++;
            end else begin
                blocked++;
            end
            tick();
            if (acc) begin
                check("fair_wait_clr", dut.wait_cnt_q, 0);
                bus.query_x = 5'($urandom_range(0, 31));
                bus.query_y = 5'($urandom_range(0, 31));
            end
        end
        check("fair_accepts", n_acc >= 5, 1);
        bus.video_row_req = 1'b0;
        bus.query_valid   = 1'b0;
        repeat (6) tick();
        do_reset();
        vid_chk_en = 1'b1;

        // Overrun: row 7 parked, query wins on saturated wait, row 9 arrives
        // during Q_RD and overwrites it; rows 1, 2, 9 are fetched.
        vid_exp.push_back(5'd1);
        vid_exp.push_back(5'd2);
        vid_exp.push_back(5'd9);
        bus.video_row_req = 1'b1;
        bus.video_row     = 5'd1;
        bus.query_valid   = 1'b1;
        bus.query_x       = 5'd1;
        bus.query_y       = 5'd9;
        tick();
        bus.video_row = 5'd2;
        tick();
        bus.video_row_req = 1'b0;
        tick();
        bus.video_row_req = 1'b1;
        bus.video_row     = 5'd7;
        tick();
        bus.video_row_req = 1'b0;
        #1 check("ovr_q_win", bus.query_ready, 1);
        tick();
        bus.video_row_req = 1'b1;
        bus.video_row     = 5'd9;
        bus.query_valid   = 1'b0;
        check("ovr_before", bus.vid_overrun, 0);
        tick();
        bus.video_row_req = 1'b0;
        check("ovr_set", bus.vid_overrun, 1);
        check("ovr_resp", bus.resp_valid, 1);
        tick();
        check("ovr_addr9", map_addr, 9);
        tick();
        check("ovr_line9", bus.line_ready, 1);
        repeat (3) tick();
        check("ovr_sticky", bus.vid_overrun, 1);

        // Reset during Q_RD drops the access
        bus.video_col   = 5'd1;
        bus.query_valid = 1'b1;
        bus.query_x     = 5'd31;
        bus.query_y     = 5'd3;
        tick();
        bus.query_valid = 1'b0;
        reset = 1'b1;
        tick();
        check("mid_rst_resp_valid", bus.resp_valid, 0);
        check("mid_rst_resp_hit", bus.resp_hit, 0);
        check("mid_rst_map_addr", map_addr, 0);
        check("mid_rst_line_ready", bus.line_ready, 0);
        check("mid_rst_overrun", bus.vid_overrun, 0);
        check("mid_rst_pixel", bus.video_pixel, 0);
        reset = 1'b0;
        q_exp.delete();
        tick();
        check("post_rst_no_resp", bus.resp_valid, 0);
        bus.query_valid = 1'b1;
        #1 check("post_rst_ready", bus.query_ready, 1);
        tick();
        bus.query_valid = 1'b0;
        tick();
        check("post_rst_resp", bus.resp_valid, 1);
        check("post_rst_hit", bus.resp_hit, 1);
        repeat (3) tick();

        check("vid_q_empty", vid_exp.size(), 0);
        check("q_q_empty", q_exp.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
